slc3_regfile_cc: RTL and testbench

- Parametrised register file with condition-code and branch-enable logic for the SLC-3 datapath.
- Generalises the fixed 8 x 16-bit file to N_REGS x WIDTH, with two asynchronous read ports, one synchronous write port, an NZP/BEN unit and a handshaked register-dump sequencer.
- The dump sequencer feeds the debug/hex display path.
- Sits between the datapath bus, the IR decode fields and the ISDU.

---
 rtl/slc3_regfile_cc_if.sv | 43 ++++
 rtl/slc3_regfile_cc.sv | 126 ++++++++++++
 tb/tb_slc3_regfile_cc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/slc3_regfile_cc_if.sv
// Register-file bus for slc3_regfile_cc: datapath/ISDU controls, read ports,
// condition codes and the register-dump stream to the debug display.
interface slc3_regfile_cc_if #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8
);
    localparam int IDX_W = $clog2(N_REGS);

    logic             LD_REG;
    logic [IDX_W-1:0] DR;
    logic [WIDTH-1:0] D_in;
    logic [IDX_W-1:0] SR1;
    logic [IDX_W-1:0] SR2;
    logic [WIDTH-1:0] SR1_out;
    logic [WIDTH-1:0] SR2_out;
    logic             LD_CC;
    logic [WIDTH-1:0] CC_in;
    logic             LD_BEN;
    logic [2:0]       IR_nzp;
    logic [2:0]       nzp;
    logic             BEN;
    logic             dump_start;
    logic             dump_ready;
    logic             dump_valid;
    logic [IDX_W-1:0] dump_idx;
    logic [WIDTH-1:0] dump_data;
    logic             dump_busy;
    logic             dump_done;

    modport master (
        output LD_REG, DR, D_in, SR1, SR2, LD_CC, CC_in, LD_BEN, IR_nzp,
               dump_start, dump_ready,
        input  SR1_out, SR2_out, nzp, BEN,
               dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  LD_REG, DR, D_in, SR1, SR2, LD_CC, CC_in, LD_BEN, IR_nzp,
               dump_start, dump_ready,
        output SR1_out, SR2_out, nzp, BEN,
               dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/slc3_regfile_cc.sv
// SLC-3 register file with NZP/BEN logic and a handshaked register-dump sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read and dump ports.
module slc3_regfile_cc #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    slc3_regfile_cc_if.slave   rf
);
    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } dump_state_t;

    logic [WIDTH-1:0] regs [N_REGS];
    logic [2:0]       nzp_q;
    logic             ben_q;
    dump_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dump_valid, dump_busy, dump_done;

    function automatic logic [2:0] cc_decode(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // NOTE: the array is reset in a loop, so it maps to flops rather than a RAM
    // macro; that is intended, the architectural reset state is all zeros.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_REGS; i++)
                regs[i] <= '0;
        end else if (rf.LD_REG) begin
            regs[rf.DR] <= rf.D_in;
        end
    end

    // NOTE: non-blocking updates are what make BEN see the pre-edge nzp when
    // LD_CC and LD_BEN fire in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (rf.LD_CC)
                nzp_q <= cc_decode(rf.CC_in);
            if (rf.LD_BEN)
                ben_q <= |(nzp_q & rf.IR_nzp);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rf.dump_start) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (rf.dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1);
                    end
                end
            end
            S_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                idx_d     = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

`ifdef REGFILE_BYPASS_EN
    assign rf.SR1_out   = (rf.LD_REG && rf.SR1 == rf.DR) ? rf.D_in : regs[rf.SR1];
    assign rf.SR2_out   = (rf.LD_REG && rf.SR2 == rf.DR) ? rf.D_in : regs[rf.SR2];
    assign rf.dump_data = (rf.LD_REG && idx_q == rf.DR) ? rf.D_in : regs[idx_q];
`else
    assign rf.SR1_out   = regs[rf.SR1];
    assign rf.SR2_out   = regs[rf.SR2];
    assign rf.dump_data = regs[idx_q];
`endif

    assign rf.nzp        = nzp_q;
    assign rf.BEN        = ben_q;
    assign rf.dump_idx   = idx_q;
    assign rf.dump_valid = dump_valid;
    assign rf.dump_busy  = dump_busy;
    assign rf.dump_done  = dump_done;
endmodule

// File: tb/tb_slc3_regfile_cc.sv
// Directed bench for slc3_regfile_cc: default 16x8 instance plus a 32x16 instance.
module tb_slc3_regfile_cc;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    slc3_regfile_cc_if #(.WIDTH(16), .N_REGS(8))  bus ();
    slc3_regfile_cc_if #(.WIDTH(32), .N_REGS(16)) bus32 ();

    slc3_regfile_cc #(.WIDTH(16), .N_REGS(8))  dut   (.Clk(Clk), .Reset(Reset), .rf(bus));
    slc3_regfile_cc #(.WIDTH(32), .N_REGS(16)) dut32 (.Clk(Clk), .Reset(Reset), .rf(bus32));

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_v;

        Reset = 1'b1;
        bus.LD_REG = 0; bus.DR = '0; bus.D_in = '0; bus.SR1 = '0; bus.SR2 = '0;
        bus.LD_CC = 0; bus.CC_in = '0; bus.LD_BEN = 0; bus.IR_nzp = '0;
        bus.dump_start = 0; bus.dump_ready = 0;
        bus32.LD_REG = 0; bus32.DR = '0; bus32.D_in = '0; bus32.SR1 = '0; bus32.SR2 = '0;
        bus32.LD_CC = 0; bus32.CC_in = '0; bus32.LD_BEN = 0; bus32.IR_nzp = '0;
        bus32.dump_start = 0; bus32.dump_ready = 0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        check("rst_nzp", bus.nzp, 3'b010);
        check("rst_ben", bus.BEN, 0);
        check("rst_valid", bus.dump_valid, 0);
        check("rst_busy", bus.dump_busy, 0);
        check("rst_done", bus.dump_done, 0);
        check("rst_idx", bus.dump_idx, 0);
        check("rst_nzp32", bus32.nzp, 3'b010);

        // Write R3 then read it back on the following cycle
        bus.LD_REG = 1; bus.DR = 3'd3; bus.D_in = 16'h1234;
        tick();
        bus.LD_REG = 0; bus.SR1 = 3'd3; bus.SR2 = 3'd0;
        #1;
        check("wr_r3_sr1", bus.SR1_out, 16'h1234);
        check("wr_r3_sr2", bus.SR2_out, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            if (k != 3) begin
                bus.SR2 = 3'(k);
                #1;
                check($sformatf("zero_r%0d", k), bus.SR2_out, 16'h0000);
            end
        end

        // Condition codes
        bus.LD_CC = 1; bus.CC_in = 16'h8000;
        tick();
        check("cc_neg", bus.nzp, 3'b100);
        bus.CC_in = 16'h0000;
        tick();
        check("cc_zero", bus.nzp, 3'b010);
        bus.CC_in = 16'h0001;
        tick();
        check("cc_pos", bus.nzp, 3'b001);
        bus.LD_CC = 0;

        // Branch enable, including simultaneous LD_CC/LD_BEN
        bus.LD_BEN = 1; bus.IR_nzp = 3'b011;
        tick();
        check("ben_p_hit", bus.BEN, 1);
        bus.LD_CC = 1; bus.CC_in = 16'h8000; bus.IR_nzp = 3'b001;
        tick();
        check("ben_old_nzp", bus.BEN, 1);
        check("nzp_new", bus.nzp, 3'b100);
        bus.LD_CC = 0;
        tick();
        check("ben_miss", bus.BEN, 0);
        bus.LD_BEN = 0;

        // Load Rk = 0x0100 + k, then a full dump with ready held high
        for (int k = 0; k < 8; k++) begin
            bus.LD_REG = 1; bus.DR = 3'(k); bus.D_in = 16'(16'h0100 + k);
            tick();
        end
        bus.LD_REG = 0;
        bus.dump_start = 1; bus.dump_ready = 1;
        tick();
        bus.dump_start = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("dump_idx%0d", k), bus.dump_idx, k);
            check($sformatf("dump_data%0d", k), bus.dump_data, 16'(16'h0100 + k));
            check($sformatf("dump_valid%0d", k), bus.dump_valid, 1);
            check($sformatf("dump_nodone%0d", k), bus.dump_done, 0);
            tick();
        end
        check("dump_done", bus.dump_done, 1);
        check("dump_done_novalid", bus.dump_valid, 0);
        check("dump_done_busy", bus.dump_busy, 1);
        tick();
        check("dump_done_once", bus.dump_done, 0);
        check("dump_idle_busy", bus.dump_busy, 0);
        check("dump_idle_idx", bus.dump_idx, 0);

        // Stall at idx 2, ignored dump_start, live dump_data, then abort by Reset
        bus.dump_start = 1;
        tick();
        bus.dump_start = 0;
        tick();
        tick();
        bus.dump_ready = 0;
        check("stall_at2", bus.dump_idx, 2);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_idx_c%0d", c), bus.dump_idx, 2);
            check($sformatf("stall_valid_c%0d", c), bus.dump_valid, 1);
        end
        bus.dump_start = 1;
        tick();
        bus.dump_start = 0;
        check("start_ignored_idx", bus.dump_idx, 2);
        check("start_ignored_valid", bus.dump_valid, 1);
        bus.LD_REG = 1; bus.DR = 3'd2; bus.D_in = 16'hAAAA;
        #1;
        exp_v = BYPASS ? 64'hAAAA : 64'h0102;
        check("dump_live_same", bus.dump_data, exp_v);
        tick();
        bus.LD_REG = 0;
        check("dump_live_next", bus.dump_data, 16'hAAAA);

        Reset = 1; bus.dump_ready = 1;
        bus.LD_REG = 1; bus.DR = 3'd3; bus.D_in = 16'h5555;
        tick();
        check("abort_valid", bus.dump_valid, 0);
        check("abort_busy", bus.dump_busy, 0);
        check("abort_done", bus.dump_done, 0);
        check("abort_idx", bus.dump_idx, 0);
        check("abort_nzp", bus.nzp, 3'b010);
        Reset = 0; bus.LD_REG = 0; bus.dump_ready = 0;
        bus.SR1 = 3'd3;
        #1;
        check("reset_beats_write", bus.SR1_out, 16'h0000);
        tick();
        check("abort_no_done", bus.dump_done, 0);

        // Same-cycle read of a register being written
        bus.LD_REG = 1; bus.DR = 3'd5; bus.D_in = 16'hBEEF; bus.SR1 = 3'd5;
        #1;
        exp_v = BYPASS ? 64'hBEEF : 64'h0000;
        check("bypass_same", bus.SR1_out, exp_v);
        tick();
        bus.LD_REG = 0;
        check("bypass_next", bus.SR1_out, 16'hBEEF);

        // 32-bit, 16-entry instance
        bus32.LD_REG = 1; bus32.DR = 4'd15; bus32.D_in = 32'hFFFF_FFFF;
        tick();
        bus32.LD_REG = 0; bus32.SR1 = 4'd15; bus32.SR2 = 4'd0;
        #1;
        check("w32_r15", bus32.SR1_out, 32'hFFFF_FFFF);
        check("w32_r0", bus32.SR2_out, 32'h0000_0000);
        bus32.LD_CC = 1; bus32.CC_in = 32'hFFFF_FFFF;
        tick();
        bus32.LD_CC = 0;
        check("w32_cc_neg", bus32.nzp, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
